// File: rtl/clkgen_ctrl_if.sv
// Control/status bundle for the serial-clock generator: config handshake,
// start/stop commands and the generated clock with its edge strobes.
interface clkgen_ctrl_if #(
  parameter int DIV_BITS = 16,
  parameter int CNT_BITS = 8
);
  logic [DIV_BITS-1:0] in_cfg_half;
  logic                in_cfg_valid;
  logic                out_cfg_ready;
  logic [CNT_BITS-1:0] in_burst_len;
  logic                in_start;
  logic                in_stop;
  logic                out_clk;
  logic                out_rise;
  logic                out_fall;
  logic                out_busy;
  logic                out_done;

  modport master (
    output in_cfg_half, in_cfg_valid, in_burst_len, in_start, in_stop,
    input  out_cfg_ready, out_clk, out_rise, out_fall, out_busy, out_done
  );

  modport slave (
    input  in_cfg_half, in_cfg_valid, in_burst_len, in_start, in_stop,
    output out_cfg_ready, out_clk, out_rise, out_fall, out_busy, out_done
  );
endinterface

// File: rtl/clkgen_ctrl.sv
// Programmable serial-clock generator: divides in_clk by a half-period and runs
// continuously or for a burst; config changes and stops land on period boundaries.
module clkgen_ctrl #(
  parameter int          DIV_BITS     = 16,
  parameter int          CNT_BITS     = 8,
  parameter int          DEFAULT_HALF = 2500,
  parameter logic        CLK_INIT     = 1'b0
) (
  input  logic          in_clk,
  input  logic          in_rst,
  clkgen_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_reg, state_next;
  logic [DIV_BITS-1:0] half_reg, half_next;
  logic [DIV_BITS-1:0] hcnt_reg, hcnt_next;
  logic [CNT_BITS-1:0] pcnt_reg, pcnt_next;
  logic [CNT_BITS-1:0] len_reg, len_next;
  logic                pend_reg, pend_next;
  logic [DIV_BITS-1:0] pend_half_reg, pend_half_next;
  logic                stop_reg, stop_next;
  logic                clk_reg, clk_next;
  logic                rise_reg, rise_next;
  logic                fall_reg, fall_next;
  logic                done_reg, done_next;

  logic [DIV_BITS-1:0] half_eff;
  logic [DIV_BITS-1:0] term;
  logic [CNT_BITS-1:0] pcnt_inc;
  logic                cfg_ready;
  logic                cfg_fire;
  logic                toggle;
  logic                complete;
  logic                end_run;

  // A programmed half-period of zero behaves as one.
  assign half_eff  = (half_reg == '0) ? DIV_BITS'(1) : half_reg;
  assign term      = half_eff - DIV_BITS'(1);
  assign pcnt_inc  = (pcnt_reg == '1) ? pcnt_reg : pcnt_reg + CNT_BITS'(1);
  assign cfg_ready = (state_reg == IDLE) || !pend_reg;
  assign cfg_fire  = bus.in_cfg_valid && cfg_ready;
  assign toggle    = (state_reg == RUN) && (hcnt_reg == term);
  assign complete  = toggle && (clk_reg != CLK_INIT);
  assign end_run   = complete && (stop_reg || bus.in_stop ||
                     ((len_reg != '0) && (pcnt_inc == len_reg)));

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg     <= IDLE;
      half_reg      <= DIV_BITS'(DEFAULT_HALF);
      hcnt_reg      <= '0;
      pcnt_reg      <= '0;
      len_reg       <= '0;
      pend_reg      <= 1'b0;
      pend_half_reg <= '0;
      stop_reg      <= 1'b0;
      clk_reg       <= CLK_INIT;
      rise_reg      <= 1'b0;
      fall_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      half_reg      <= half_next;
      hcnt_reg      <= hcnt_next;
      pcnt_reg      <= pcnt_next;
      len_reg       <= len_next;
      pend_reg      <= pend_next;
      pend_half_reg <= pend_half_next;
      stop_reg      <= stop_next;
      clk_reg       <= clk_next;
      rise_reg      <= rise_next;
      fall_reg      <= fall_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    half_next      = half_reg;
    hcnt_next      = hcnt_reg;
    pcnt_next      = pcnt_reg;
    len_next       = len_reg;
    pend_next      = pend_reg;
    pend_half_next = pend_half_reg;
    stop_next      = stop_reg;
    clk_next       = clk_reg;
    rise_next      = 1'b0;
    fall_next      = 1'b0;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cfg_fire) half_next = bus.in_cfg_half;
        if (bus.in_start) begin
          state_next = RUN;
          hcnt_next  = '0;
          pcnt_next  = '0;
          len_next   = bus.in_burst_len;
          stop_next  = bus.in_stop;
          clk_next   = CLK_INIT;
        end
      end
      RUN: begin
        hcnt_next = toggle ? '0 : hcnt_reg + DIV_BITS'(1);
        if (bus.in_stop) stop_next = 1'b1;
        if (toggle) begin
          clk_next  = ~clk_reg;
          rise_next = ~clk_reg;
          fall_next = clk_reg;
        end
        if (complete) begin
          pcnt_next = pcnt_inc;
          if (pend_reg) begin
            half_next = pend_half_reg;
            pend_next = 1'b0;
          end
        end
        if (end_run) begin
          state_next = IDLE;
          stop_next  = 1'b0;
          done_next  = 1'b1;
        end
        // A config taken on the final boundary has no later boundary, so load it now.
        if (cfg_fire) begin
          if (end_run) begin
            half_next = bus.in_cfg_half;
          end else begin
            pend_next      = 1'b1;
            pend_half_next = bus.in_cfg_half;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.out_cfg_ready = cfg_ready;
  assign bus.out_clk       = clk_reg;
  assign bus.out_rise      = rise_reg;
  assign bus.out_fall      = fall_reg;
  assign bus.out_busy      = (state_reg == RUN);
  assign bus.out_done      = done_reg;
endmodule

// File: tb/tb_clkgen_ctrl.sv
// Bench for clkgen_ctrl: directed scenarios then random traffic, every cycle
// compared against a period-position reference model.
module tb_clkgen_ctrl;
  localparam int   DB  = 16;
  localparam int   CB  = 8;
  localparam int   DEF = 7;
  localparam logic CI  = 1'b0;

  logic in_clk = 1'b0;
  logic in_rst;
  always #5 in_clk = ~in_clk;

  clkgen_ctrl_if #(.DIV_BITS(DB), .CNT_BITS(CB)) bus ();

  clkgen_ctrl #(.DIV_BITS(DB), .CNT_BITS(CB), .DEFAULT_HALF(DEF), .CLK_INIT(CI)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc           = 0;
  int start_cyc     = 0;
  int done_cyc      = -1;

  // Reference model: position within the current out_clk period.
  bit m_run, m_clk, m_pv, m_stop;
  int m_p, m_half, m_pvh, m_len, m_per;
  bit e_rise, e_fall, e_done;

  task automatic check(input string tag, input int obs, input int exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cv,
                            input int ch, input int bl, input bit rs);
    int h;
    bit acc, ending;
    e_rise = 0; e_fall = 0; e_done = 0;
    if (rs) begin
      m_run = 0; m_clk = CI; m_half = DEF; m_pv = 0; m_stop = 0;
    end else if (!m_run) begin
      if (cv) m_half = ch;
      if (st) begin
        m_run = 1; m_p = 0; m_per = 0; m_len = bl; m_stop = sp; m_clk = CI;
      end
    end else begin
      acc    = cv && !m_pv;
      h      = (m_half == 0) ? 1 : m_half;
      ending = 0;
      m_p++;
      if (m_p == h) begin
        m_clk = ~CI; e_rise = (m_clk == 1'b1); e_fall = (m_clk == 1'b0);
      end else if (m_p == 2 * h) begin
        m_clk = CI; e_rise = (m_clk == 1'b1); e_fall = (m_clk == 1'b0);
        m_p = 0;
        if (m_per < 255) m_per++;
        if (m_pv) begin m_half = m_pvh; m_pv = 0; end
        ending = m_stop || sp || (m_len != 0 && m_per == m_len);
      end
      if (sp) m_stop = 1;
      if (ending) begin m_run = 0; m_stop = 0; e_done = 1; end
      if (acc) begin
        if (ending) m_half = ch;
        else begin m_pv = 1; m_pvh = ch; end
      end
    end
  endtask

  task automatic step(input bit st, input bit sp, input bit cv,
                      input int ch, input int bl, input bit rs);
    in_rst           = rs;
    bus.in_start     = st;
    bus.in_stop      = sp;
    bus.in_cfg_valid = cv;
    bus.in_cfg_half  = DB'(ch);
    bus.in_burst_len = CB'(bl);
    if (st && !m_run && !rs) start_cyc = cyc + 1;
    model_step(st, sp, cv, ch, bl, rs);
    @(posedge in_clk);
    #1;
    cyc++;
    if (bus.out_done === 1'b1) done_cyc = cyc;
    check("clk",   int'(bus.out_clk),       int'(m_clk));
    check("rise",  int'(bus.out_rise),      int'(e_rise));
    check("fall",  int'(bus.out_fall),      int'(e_fall));
    check("busy",  int'(bus.out_busy),      int'(m_run));
    check("done",  int'(bus.out_done),      int'(e_done));
    check("ready", int'(bus.out_cfg_ready), int'(!m_run || !m_pv));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    in_rst = 1'b1;
    bus.in_start = 0; bus.in_stop = 0; bus.in_cfg_valid = 0;
    bus.in_cfg_half = '0; bus.in_burst_len = '0;
    m_run = 0; m_clk = CI; m_pv = 0; m_stop = 0; m_p = 0;
    m_half = DEF; m_pvh = 0; m_len = 0; m_per = 0;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    idle_cycles(2);

    // Burst of two periods, half=3, config and start together.
    done_cyc = -1;
    step(1, 0, 1, 3, 2, 0);
    idle_cycles(14);
    check("burst_done_at", done_cyc - start_cyc, 12);

    // Continuous half=2, re-config to 5 while high.
    step(1, 0, 1, 2, 0, 0);
    idle_cycles(2);
    step(0, 0, 1, 5, 0, 0);
    idle_cycles(22);
    done_cyc = -1;
    step(0, 1, 0, 0, 0, 0);
    idle_cycles(12);
    check("cfg_stop_done_seen", int'(done_cyc > 0), 1);

    // Continuous half=4, stop at cycle 13 lands on the cycle-16 boundary.
    done_cyc = -1;
    step(1, 0, 1, 4, 0, 0);
    idle_cycles(12);
    step(0, 1, 0, 0, 0, 0);
    idle_cycles(10);
    check("stop_done_at", done_cyc - start_cyc, 16);

    // Half of zero acts as one.
    done_cyc = -1;
    step(1, 0, 1, 0, 1, 0);
    idle_cycles(4);
    check("half0_done_at", done_cyc - start_cyc, 2);

    // Reset while out_clk is high, then a run at the default half-period.
    step(1, 0, 1, 3, 0, 0);
    idle_cycles(4);
    step(0, 0, 0, 0, 0, 1);
    done_cyc = -1;
    step(1, 0, 0, 0, 1, 0);
    idle_cycles(16);
    check("default_done_at", done_cyc - start_cyc, 2 * DEF);

    // Start and stop together: exactly one period; lone stop in IDLE ignored.
    done_cyc = -1;
    step(1, 1, 1, 2, 0, 0);
    idle_cycles(6);
    check("startstop_done_at", done_cyc - start_cyc, 4);
    step(0, 1, 0, 0, 0, 0);
    idle_cycles(3);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 6)),
           int'($urandom_range(0, 4)), $urandom_range(0, 599) == 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
